// File: rtl/memarb.sv
// Two-port arbiter onto the single mem req/ack channel: A has fixed priority, and B is forced after MAXA A grants.
// Latency: memreq 1 cycle after grant, ack 1 cycle after memack; requesters stall on held req until their ack pulse.
module memarb #(
   parameter int AW   = 20,
   parameter int DW   = 32,
   parameter int MAXA = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          areq,
   input  logic [AW-1:0] aaddr,
   input  logic          awr,
   input  logic [DW-1:0] awdata,
   output logic          aack,
   output logic [DW-1:0] ardata,
   input  logic          breq,
   input  logic [AW-1:0] baddr,
   output logic          back,
   output logic [DW-1:0] brdata,
   output logic          memreq,
   output logic [AW-1:0] memaddr,
   output logic          memwr,
   output logic [DW-1:0] memwdata,
   input  logic          memack,
   input  logic [DW-1:0] memrdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BUSYA = 3'd1,
      BUSYB = 3'd2,
      DONEA = 3'd3,
      DONEB = 3'd4
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAXA);

   state_t     state;
   logic [3:0] streak;
   logic       grant_b;
   logic       grant_a;

   // B wins when A is absent or A has used up its consecutive-grant allowance.
   assign grant_b = breq && (!areq || (streak >= STREAK_MAX));
   assign grant_a = areq && !grant_b;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         streak   <= 4'd0;
         aack     <= 1'b0;
         back     <= 1'b0;
         ardata   <= '0;
         brdata   <= '0;
         memreq   <= 1'b0;
         memaddr  <= '0;
         memwr    <= 1'b0;
         memwdata <= '0;
      end else begin
         aack <= 1'b0;
         back <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_b) begin
                  memaddr <= baddr;
                  memwr   <= 1'b0;
                  memreq  <= 1'b1;
                  streak  <= 4'd0;
                  state   <= BUSYB;
               end else if (grant_a) begin
                  memaddr  <= aaddr;
                  memwr    <= awr;
                  memwdata <= awdata;
                  memreq   <= 1'b1;
                  state    <= BUSYA;
                  if (breq) begin
                     streak <= (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
                  end else begin
                     streak <= 4'd0;
                  end
               end
            end
            BUSYA: begin
               if (memack) begin
                  memreq <= 1'b0;
                  memwr  <= 1'b0;
                  aack   <= 1'b1;
                  state  <= DONEA;
                  if (!memwr) begin
                     ardata <= memrdata;
                  end
               end
            end
            BUSYB: begin
               if (memack) begin
                  memreq <= 1'b0;
                  memwr  <= 1'b0;
                  back   <= 1'b1;
                  brdata <= memrdata;
                  state  <= DONEB;
               end
            end
            DONEA: state <= IDLE;
            DONEB: state <= IDLE;
            default: begin
               memreq <= 1'b0;
               memwr  <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb with a behavioural mem responder.
module tb_memarb;
   localparam int AW = 20;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          areq = 1'b0;
   logic [AW-1:0] aaddr = '0;
   logic          awr = 1'b0;
   logic [DW-1:0] awdata = '0;
   logic          aack;
   logic [DW-1:0] ardata;
   logic          breq = 1'b0;
   logic [AW-1:0] baddr = '0;
   logic          back;
   logic [DW-1:0] brdata;
   logic          memreq;
   logic [AW-1:0] memaddr;
   logic          memwr;
   logic [DW-1:0] memwdata;
   logic          memack;
   logic [DW-1:0] memrdata;

   int tests = 0;
   int fails = 0;

   // responder controls (written only by the main block)
   logic          mem_auto = 1'b0;
   int            mem_lat = 5;
   logic [DW-1:0] mem_base = '0;
   int            txn_base = 0;
   int            inject_req = 0;
   logic [DW-1:0] inject_data = '0;
   // responder state (written only by the responder)
   int            txn = 0;
   int            inject_done = 0;

   memarb #(.AW(AW), .DW(DW), .MAXA(4)) dut (
      .clk(clk), .rstn(rstn),
      .areq(areq), .aaddr(aaddr), .awr(awr), .awdata(awdata),
      .aack(aack), .ardata(ardata),
      .breq(breq), .baddr(baddr), .back(back), .brdata(brdata),
      .memreq(memreq), .memaddr(memaddr), .memwr(memwr), .memwdata(memwdata),
      .memack(memack), .memrdata(memrdata)
   );

   always #5 clk = ~clk;

   // mem model: memack mem_lat cycles after memreq is first seen, or an injected stray pulse
   initial begin : responder
      bit active;
      int cnt;
      active = 1'b0;
      cnt = 0;
      memack = 1'b0;
      memrdata = '0;
      forever begin
         @(negedge clk);
         #1;
         memack = 1'b0;
         if (inject_req != inject_done) begin
            memack = 1'b1;
            memrdata = inject_data;
            inject_done++;
         end else if (mem_auto) begin
            if (!active && memreq) begin
               active = 1'b1;
               cnt = 1;
            end else if (active) begin
               cnt++;
            end
            if (active && cnt >= mem_lat) begin
               memack = 1'b1;
               memrdata = mem_base + 32'(txn - txn_base);
               txn++;
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      tests++;
      if ({memreq, memwr, aack, back} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ctrl: memreq/memwr/aack/back=%b required 0000", {memreq, memwr, aack, back});
      end
      tests++;
      if (memaddr !== '0 || memwdata !== '0 || ardata !== '0 || brdata !== '0) begin
         fails++;
         $display("FAIL reset_data: memaddr=%h memwdata=%h ardata=%h brdata=%h required all 0", memaddr, memwdata, ardata, brdata);
      end
      rstn = 1'b1;
      tick();
      tick();
      tests++;
      if (memreq !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: memreq=%b required 0", memreq);
      end
   endtask

   task automatic test_a_read();
      int n;
      logic prev_mack;
      mem_auto = 1'b1;
      mem_lat = 5;
      mem_base = 32'hDEADBEEF;
      txn_base = txn;
      aaddr = 20'h01234;
      awr = 1'b0;
      areq = 1'b1;
      tick();
      tests++;
      if (memreq !== 1'b1 || memaddr !== 20'h01234 || memwr !== 1'b0) begin
         fails++;
         $display("FAIL read_issue: memreq=%b memaddr=%h memwr=%b required 1 01234 0", memreq, memaddr, memwr);
      end
      n = 0;
      prev_mack = 1'b0;
      while (aack !== 1'b1 && n < 40) begin
         prev_mack = memack;
         tick();
         n++;
      end
      tests++;
      if (aack !== 1'b1 || prev_mack !== 1'b1) begin
         fails++;
         $display("FAIL read_ack: aack=%b memack_prev_cycle=%b required 1 1", aack, prev_mack);
      end
      tests++;
      if (ardata !== 32'hDEADBEEF || memreq !== 1'b0) begin
         fails++;
         $display("FAIL read_data: ardata=%h memreq=%b required deadbeef 0", ardata, memreq);
      end
      areq = 1'b0;
      tick();
      tests++;
      if (aack !== 1'b0) begin
         fails++;
         $display("FAIL read_pulse: aack=%b required 0 one cycle later", aack);
      end
   endtask

   task automatic test_a_write();
      int n;
      bit held_ok;
      mem_lat = 4;
      mem_base = 32'h0BADF00D;
      txn_base = txn;
      aaddr = 20'h00010;
      awr = 1'b1;
      awdata = 32'hCAFEF00D;
      areq = 1'b1;
      tick();
      n = 0;
      held_ok = 1'b1;
      while (aack !== 1'b1 && n < 40) begin
         if (memreq !== 1'b1 || memwr !== 1'b1 || memwdata !== 32'hCAFEF00D || memaddr !== 20'h00010) held_ok = 1'b0;
         tick();
         n++;
      end
      tests++;
      if (held_ok !== 1'b1 || n < 3) begin
         fails++;
         $display("FAIL write_hold: held_ok=%b busy_cycles=%0d required 1 and >=3", held_ok, n);
      end
      tests++;
      if (aack !== 1'b1 || ardata !== 32'hDEADBEEF || memwr !== 1'b0) begin
         fails++;
         $display("FAIL write_ack: aack=%b ardata=%h memwr=%b required 1 deadbeef 0", aack, ardata, memwr);
      end
      areq = 1'b0;
      awr = 1'b0;
      tick();
      tests++;
      if (aack !== 1'b0) begin
         fails++;
         $display("FAIL write_pulse: aack=%b required 0", aack);
      end
   endtask

   task automatic test_starvation();
      logic [9:0] order;
      logic [9:0] exp_order;
      int k;
      int n;
      bit both;
      exp_order = 10'b1000010000;
      order = '0;
      mem_lat = 2;
      mem_base = 32'h50000000;
      txn_base = txn;
      aaddr = 20'h00AAA;
      baddr = 20'h00BBB;
      awr = 1'b0;
      areq = 1'b1;
      breq = 1'b1;
      k = 0;
      n = 0;
      both = 1'b0;
      while (k < 10 && n < 400) begin
         tick();
         n++;
         if (aack && back) both = 1'b1;
         if (aack) begin
            order[k] = 1'b0;
            k++;
         end else if (back) begin
            order[k] = 1'b1;
            if (k == 4) begin
               tests++;
               if (brdata !== 32'h50000004) begin
                  fails++;
                  $display("FAIL starve_b_data: brdata=%h required 50000004", brdata);
               end
            end
            k++;
         end
      end
      areq = 1'b0;
      breq = 1'b0;
      tests++;
      if (k != 10 || order !== exp_order || both) begin
         fails++;
         $display("FAIL starve_order: acks=%0d order=%b both=%b required 10 %b 0", k, order, both, exp_order);
      end
      tests++;
      if (ardata !== 32'h50000008 || brdata !== 32'h50000009) begin
         fails++;
         $display("FAIL starve_final: ardata=%h brdata=%h required 50000008 50000009", ardata, brdata);
      end
      tick();
      tick();
   endtask

   task automatic test_simultaneous();
      int na;
      int nb;
      logic first_b;
      bit got_first;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      mem_lat = 3;
      mem_base = 32'h60000000;
      txn_base = txn;
      aaddr = 20'h00111;
      baddr = 20'h00222;
      awr = 1'b0;
      areq = 1'b1;
      breq = 1'b1;
      tick();
      tests++;
      if (memreq !== 1'b1 || memaddr !== 20'h00111) begin
         fails++;
         $display("FAIL simul_first_grant: memreq=%b memaddr=%h required 1 00111", memreq, memaddr);
      end
      na = 0;
      nb = 0;
      first_b = 1'b0;
      got_first = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (aack) begin
            na++;
            areq = 1'b0;
            if (!got_first) begin got_first = 1'b1; first_b = 1'b0; end
         end
         if (back) begin
            nb++;
            breq = 1'b0;
            if (!got_first) begin got_first = 1'b1; first_b = 1'b1; end
         end
         tick();
      end
      tests++;
      if (na != 1 || nb != 1 || first_b !== 1'b0 || !got_first) begin
         fails++;
         $display("FAIL simul_acks: aacks=%0d backs=%0d first_is_b=%b required 1 1 0", na, nb, first_b);
      end
      tests++;
      if (ardata !== 32'h60000000 || brdata !== 32'h60000001) begin
         fails++;
         $display("FAIL simul_data: ardata=%h brdata=%h required 60000000 60000001", ardata, brdata);
      end
   endtask

   task automatic test_reset_midop();
      bit saw_back;
      bit saw_req;
      int n;
      mem_auto = 1'b0;
      baddr = 20'h00333;
      breq = 1'b1;
      tick();
      tests++;
      if (memreq !== 1'b1 || memaddr !== 20'h00333) begin
         fails++;
         $display("FAIL midop_busyb: memreq=%b memaddr=%h required 1 00333", memreq, memaddr);
      end
      tick();
      tick();
      rstn = 1'b0;
      breq = 1'b0;
      #1;
      tests++;
      if (memreq !== 1'b0 || memaddr !== '0) begin
         fails++;
         $display("FAIL midop_async: memreq=%b memaddr=%h required 0 00000", memreq, memaddr);
      end
      tick();
      rstn = 1'b1;
      tick();
      inject_data = 32'h77777777;
      inject_req++;
      saw_back = 1'b0;
      saw_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (back) saw_back = 1'b1;
         if (memreq) saw_req = 1'b1;
      end
      tests++;
      if (saw_back || saw_req || brdata !== '0) begin
         fails++;
         $display("FAIL midop_late_ack: back_seen=%b memreq_seen=%b brdata=%h required 0 0 0", saw_back, saw_req, brdata);
      end
      mem_auto = 1'b1;
      mem_lat = 2;
      mem_base = 32'h12345678;
      txn_base = txn;
      aaddr = 20'h00444;
      awr = 1'b0;
      areq = 1'b1;
      tick();
      tests++;
      if (memreq !== 1'b1 || memaddr !== 20'h00444) begin
         fails++;
         $display("FAIL midop_next_issue: memreq=%b memaddr=%h required 1 00444", memreq, memaddr);
      end
      n = 0;
      while (aack !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      tests++;
      if (aack !== 1'b1 || ardata !== 32'h12345678) begin
         fails++;
         $display("FAIL midop_next_ack: aack=%b ardata=%h required 1 12345678", aack, ardata);
      end
      areq = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_stray_memack();
      bit saw_ack;
      mem_auto = 1'b0;
      inject_data = 32'hBAD0BAD0;
      inject_req++;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (aack || back || memreq) saw_ack = 1'b1;
      end
      tests++;
      if (saw_ack) begin
         fails++;
         $display("FAIL stray_ack: aack/back/memreq activity=%b required 0", saw_ack);
      end
      tests++;
      if (ardata !== 32'h12345678 || brdata !== '0) begin
         fails++;
         $display("FAIL stray_data: ardata=%h brdata=%h required 12345678 00000000", ardata, brdata);
      end
   endtask

   initial begin
      test_reset();
      test_a_read();
      test_a_write();
      test_starvation();
      test_simultaneous();
      test_reset_midop();
      test_stray_memack();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memarb.md
Name: memarb

Overview:
- Two-client arbiter between the request producers and the DDR controller `mem`.
- Port A carries 68k traffic (read/write) from `switch`. Port B carries read-only sprite/C-ROM fetch traffic.
- Serialises both onto the single `mem` req/ack interface, one transaction at a time.
- Port A has fixed priority; a starvation limit guarantees port B progress.

Parameters:
- AW, 20, address width on all ports
- DW, 32, data width on all ports
- MAXA, 4, max consecutive A grants while breq is pending before B is forced (range 1..15)

Ports:
- clk  input  1  system clock (from memphy)
- rstn  input  1  asynchronous active-low reset
- areq  input  1  port A request level, held until aack
- aaddr  input  AW  port A address, stable while areq
- awr  input  1  port A write (1) / read (0), stable while areq
- awdata  input  DW  port A write data, stable while areq
- aack  output  1  port A completion pulse, one cycle
- ardata  output  DW  port A read data, valid while aack=1 and held afterwards
- breq  input  1  port B read request level, held until back
- baddr  input  AW  port B address, stable while breq
- back  output  1  port B completion pulse, one cycle
- brdata  output  DW  port B read data, valid while back=1 and held afterwards
- memreq  output  1  request to mem, level
- memaddr  output  AW  address to mem
- memwr  output  1  write strobe to mem
- memwdata  output  DW  write data to mem
- memack  input  1  completion pulse from mem
- memrdata  input  DW  read data from mem, valid with memack

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; streak counter=0.
  - All outputs 0, including ardata, brdata, memaddr and memwdata.
- FSM states: IDLE, BUSYA, BUSYB, DONEA, DONEB.
- IDLE grant decision:
  - Port B is granted if breq=1 and (areq=0 or streak>=MAXA).
  - Otherwise port A is granted if areq=1.
  - Otherwise stay in IDLE.
- Grant A, on the clock edge:
  - Latch memaddr<=aaddr, memwr<=awr, memwdata<=awdata; memreq<=1; go to BUSYA.
  - streak<=streak+1 if breq=1, else streak<=0. streak saturates at MAXA.
- Grant B, on the clock edge:
  - Latch memaddr<=baddr, memwr<=0, memwdata unchanged; memreq<=1; go to BUSYB; streak<=0.
- BUSYx:
  - memreq, memaddr, memwr and memwdata are held stable.
  - On memack=1: memreq<=0; memwr<=0.
  - Port A: ardata<=memrdata on reads; ardata is unchanged on writes.
  - Port B: brdata<=memrdata.
  - Go to DONEx. memack while memreq=0 is ignored.
- DONEx:
  - aack (or back)=1 for exactly this one cycle; next state is IDLE.
  - The requester must have deasserted its req by the IDLE cycle that follows.
- Latency:
  - Grant occurs on the first edge with req=1 in IDLE.
  - memreq rises 1 cycle after req is sampled.
  - ack is asserted 1 cycle after memack.
  - Minimum req-to-ack is 3 cycles plus the mem latency.
- No back-to-back grant without an IDLE cycle. Maximum throughput is one transaction per (mem latency + 3) cycles.
- Simultaneous areq and breq in IDLE with streak<MAXA: A wins. With streak>=MAXA: B wins.
- req dropped before ack: protocol violation with no defined recovery. The transaction already issued completes and the ack is still pulsed.
- rstn asserted mid-transaction:
  - Immediate return to IDLE with memreq=0.
  - A memack from the aborted transaction arriving after reset release is ignored, because memreq=0.
- ardata and brdata hold their last value until the next completed read on the same port.

Test Plan:
- Single A read: areq=1, aaddr=0x01234, awr=0; mem returns 0xDEADBEEF after 5 cycles -> memreq high with memaddr=0x01234, memwr=0; aack single pulse 1 cycle after memack; ardata=0xDEADBEEF; memreq low in DONEA.
- A write: awr=1, aaddr=0x00010, awdata=0xCAFEF00D -> memwr=1, memwdata=0xCAFEF00D through BUSYA; ardata unchanged; aack single pulse.
- Starvation, MAXA=4: areq and breq held high continuously, with A re-requesting immediately after each aack -> grant order A,A,A,A,B,A,A,A,A,B; back carries brdata=memrdata of the 5th transaction.
- Simultaneous first request: areq and breq rise on the same cycle from reset -> A granted first; B granted next; every transaction completes with exactly one ack per port.
- Reset mid-op: rstn pulsed low during BUSYB, memack arrives 2 cycles after release -> memreq=0 immediately; back never asserts; brdata=0; state IDLE; next areq served normally.
- Stray memack in IDLE: memack=1 with no outstanding request -> no aack or back; ardata and brdata unchanged.
